// File: rtl/blink_pkg.sv
// rtl/blink_pkg.sv - shared state encoding and default widths for the blink burst sequencer
package blink_pkg;

  localparam int BLINK_NBITS = 4;
  localparam int BLINK_TBITS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } blink_burst_state_e;

endpackage

// File: rtl/blink_phase_cnt.sv
// rtl/blink_phase_cnt.sv - tick-qualified phase counter with clear and terminal-count compare
module blink_phase_cnt #(
  parameter int TBITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             tick,
  input  logic [TBITS-1:0] term,
  output logic             hit
);

  logic [TBITS-1:0] cnt;

  assign hit = tick && (cnt == term);

  // The counter rewinds on its own terminal tick so consecutive phases start from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || hit) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + TBITS'(1);
    end
  end

endmodule

// File: rtl/blink_burst_seq.sv
// rtl/blink_burst_seq.sv - tick-driven LED burst sequencer (optional assertions: BLINK_BURST_SVA_EN)
module blink_burst_seq
  import blink_pkg::*;
#(
  parameter int NBITS     = BLINK_NBITS,
  parameter int TBITS     = BLINK_TBITS,
  parameter int ON_TICKS  = 1,
  parameter int OFF_TICKS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             tick,
  input  logic [NBITS-1:0] burst_len,
  input  logic [TBITS-1:0] gap_len,
  output logic             led,
  output logic             busy,
  output logic             done
);

  blink_burst_state_e state;
  logic [NBITS-1:0]   rem;
  logic [TBITS-1:0]   glen;
  logic [TBITS-1:0]   term;
  logic               hit;
  logic               abort;

  assign abort = (state != IDLE) && !en;

  always_comb begin
    term = '0;
    case (state)
      ON:      term = TBITS'(ON_TICKS - 1);
      OFF:     term = TBITS'(OFF_TICKS - 1);
      GAP:     term = glen - TBITS'(1);
      default: term = '0;
    endcase
  end

  blink_phase_cnt #(.TBITS(TBITS)) u_phase_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((state == IDLE) || abort),
    .tick  (tick),
    .term  (term),
    .hit   (hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rem   <= '0;
      glen  <= '0;
      led   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      rem   <= '0;
      glen  <= '0;
      led   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (en && tick && (burst_len != '0)) begin
            rem   <= burst_len;
            glen  <= gap_len;
            state <= ON;
            led   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        ON: begin
          if (hit) begin
            state <= OFF;
            led   <= 1'b0;
          end
        end
        OFF: begin
          if (hit) begin
            rem <= rem - NBITS'(1);
            if (rem > NBITS'(1)) begin
              state <= ON;
              led   <= 1'b1;
            end else if (glen != '0) begin
              state <= GAP;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        GAP: begin
          if (hit) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            led   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BLINK_BURST_SVA_EN
  logic [NBITS-1:0] blen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blen <= '0;
    end else if (abort) begin
      blen <= '0;
    end else if (state == IDLE && en && tick && (burst_len != '0)) begin
      blen <= burst_len;
    end
  end

  a_done_after_busy: assert property (@(posedge clk) disable iff (!rst_n) done |-> $past(busy));
  a_done_single:     assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);
  a_led_busy:        assert property (@(posedge clk) disable iff (!rst_n) led |-> busy);
  a_tick_pulse:      assert property (@(posedge clk) disable iff (!rst_n) tick |=> !tick);
  a_rem_bound:       assert property (@(posedge clk) disable iff (!rst_n) rem <= blen);
`endif

endmodule
